md_sched: RTL and testbench



---
 rtl/md_pkg.sv | 22 ++
 rtl/md_countdown.sv | 25 ++
 rtl/md_sched.sv | 124 ++++++++++++
 tb/tb_md_sched.sv | 216 +++++++++++++++++++++
 4 files changed

// File: rtl/md_pkg.sv
// Shared definitions for the multiply/divide scheduler: F codes, FSM states, default latencies.
package md_pkg;

    localparam logic [2:0] MD_NOP  = 3'd0;
    localparam logic [2:0] MD_MTHI = 3'd1;
    localparam logic [2:0] MD_MTLO = 3'd2;
    localparam logic [2:0] MD_MULT = 3'd3;
    localparam logic [2:0] MD_DIV  = 3'd4;

    localparam int MD_MUL_LAT_DEF = 4;
    localparam int MD_DIV_LAT_DEF = 32;

    typedef enum logic {
        IDLE = 1'b0,
        BUSY = 1'b1
    } md_state_e;

    function automatic int lat_max(input int a, input int b);
        return (a > b) ? a : b;
    endfunction

endpackage

// File: rtl/md_countdown.sv
// Loadable down-counter with enable and zero flag; load has priority over enable.
module md_countdown #(
    parameter int W = 6
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         load,
    input  logic [W-1:0] load_val,
    input  logic         en,
    output logic [W-1:0] cnt,
    output logic         zero
);

    always_ff @(posedge clk) begin
        if (!rst_n)
            cnt <= '0;
        else if (load)
            cnt <= load_val;
        else if (en)
            cnt <= cnt - 1'b1;
    end

    assign zero = (cnt == '0);

endmodule

// File: rtl/md_sched.sv
// Multi-cycle MULT/DIV scheduler in front of the HI/LO unit; commits on a single cycle.
// Optional MD_SCHED_STALL_CNT_EN adds a free-running stall cycle counter output.
module md_sched
    import md_pkg::*;
#(
    parameter int MUL_LAT = MD_MUL_LAT_DEF,
    parameter int DIV_LAT = MD_DIV_LAT_DEF
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        req_valid,
    input  logic [2:0]  req_f,
    input  logic        req_sign,
    input  logic [31:0] req_a,
    input  logic [31:0] req_b,
    input  logic        rd_hilo,
    input  logic        flush,
`ifdef MD_SCHED_STALL_CNT_EN
    output logic [31:0] stall_cnt,
`endif
    output logic        req_ready,
    output logic        stall,
    output logic        busy,
    output logic [2:0]  md_f,
    output logic        md_sign,
    output logic [31:0] md_a,
    output logic [31:0] md_b,
    output logic        div_zero
);

    localparam int CW = $clog2(lat_max(MUL_LAT, DIV_LAT) + 1);
    localparam logic [CW-1:0] MUL_LD = CW'(MUL_LAT - 1);
    localparam logic [CW-1:0] DIV_LD = CW'(DIV_LAT - 1);

    md_state_e   state, state_nx;
    logic [2:0]  op_f;
    logic        op_sign;
    logic [31:0] op_a, op_b;
    logic        ld;
    logic [CW-1:0] cnt;
    logic        cnt_zero;

    md_countdown #(.W(CW)) u_cnt (
        .clk      (clk),
        .rst_n    (rst_n),
        .load     (ld),
        .load_val ((req_f == MD_DIV) ? DIV_LD : MUL_LD),
        .en       (busy & ~cnt_zero),
        .cnt      (cnt),
        .zero     (cnt_zero)
    );

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state   <= IDLE;
            op_f    <= '0;
            op_sign <= 1'b0;
            op_a    <= '0;
            op_b    <= '0;
        end else begin
            state <= state_nx;
            if (ld) begin
                op_f    <= req_f;
                op_sign <= req_sign;
                op_a    <= req_a;
                op_b    <= req_b;
            end
        end
    end

    always_comb begin
        state_nx = state;
        ld       = 1'b0;
        md_f     = MD_NOP;
        md_sign  = op_sign;
        md_a     = op_a;
        md_b     = op_b;
        div_zero = 1'b0;
        case (state)
            IDLE: begin
                if (req_valid && !flush) begin
                    case (req_f)
                        MD_MTHI, MD_MTLO: begin
                            md_f    = req_f;
                            md_sign = req_sign;
                            md_a    = req_a;
                        end
                        MD_MULT, MD_DIV: begin
                            ld       = 1'b1;
                            state_nx = BUSY;
                        end
                        default: ;
                    endcase
                end
            end
            BUSY: begin
                if (flush || cnt_zero)
                    state_nx = IDLE;
                // reset in the commit cycle also suppresses the commit
                if (cnt_zero && !flush && rst_n) begin
                    if (op_f == MD_DIV && op_b == '0)
                        div_zero = 1'b1;
                    else
                        md_f = op_f;
                end
            end
            default: state_nx = IDLE;
        endcase
    end

    assign busy      = (state == BUSY);
    assign stall     = busy & (req_valid | rd_hilo);
    assign req_ready = (state == IDLE) & ~flush;

`ifdef MD_SCHED_STALL_CNT_EN
    always_ff @(posedge clk) begin
        if (!rst_n)
            stall_cnt <= '0;
        else if (stall)
            stall_cnt <= stall_cnt + 32'd1;
    end
`endif

endmodule

// File: tb/tb_md_sched.sv
// Bench for md_sched: directed scenarios plus random traffic against a latency-level reference model.
module tb_md_sched;
    import md_pkg::*;

    localparam int MUL_LAT = 4;
    localparam int DIV_LAT = 32;

    logic        clk = 1'b0;
    logic        rst_n, req_valid, req_sign, rd_hilo, flush;
    logic [2:0]  req_f;
    logic [31:0] req_a, req_b;
    logic        req_ready, stall, busy, md_sign, div_zero;
    logic [2:0]  md_f;
    logic [31:0] md_a, md_b;
`ifdef MD_SCHED_STALL_CNT_EN
    logic [31:0] stall_cnt;
`endif

    always #5 clk = ~clk;

    md_sched #(.MUL_LAT(MUL_LAT), .DIV_LAT(DIV_LAT)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .req_valid (req_valid),
        .req_f     (req_f),
        .req_sign  (req_sign),
        .req_a     (req_a),
        .req_b     (req_b),
        .rd_hilo   (rd_hilo),
        .flush     (flush),
`ifdef MD_SCHED_STALL_CNT_EN
        .stall_cnt (stall_cnt),
`endif
        .req_ready (req_ready),
        .stall     (stall),
        .busy      (busy),
        .md_f      (md_f),
        .md_sign   (md_sign),
        .md_a      (md_a),
        .md_b      (md_b),
        .div_zero  (div_zero)
    );

    // HI/LO unit as it sits behind the scheduler
    logic [31:0] hi = '0, lo = '0;
    always @(posedge clk) begin
        case (md_f)
            MD_MTHI: hi <= md_a;
            MD_MTLO: lo <= md_a;
            MD_MULT: begin
                if (md_sign)
                    {hi, lo} <= 64'($signed({{32{md_a[31]}}, md_a}) * $signed({{32{md_b[31]}}, md_b}));
                else
                    {hi, lo} <= {32'b0, md_a} * {32'b0, md_b};
            end
            MD_DIV: begin
                if (md_b != '0) begin
                    if (md_sign) begin
                        lo <= 32'($signed(md_a) / $signed(md_b));
                        hi <= 32'($signed(md_a) % $signed(md_b));
                    end else begin
                        lo <= md_a / md_b;
                        hi <= md_a % md_b;
                    end
                end
            end
            default: ;
        endcase
    end

    int n_tests = 0;
    int n_fail  = 0;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
        end
    endtask

    // Reference model: an accepted op is pending and commits exactly LAT cycles after acceptance.
    int          cyc = 0;
    bit          m_pend = 0;
    int          m_commit = 0;
    bit [2:0]    m_f = '0;
    bit          m_s = 0;
    bit [31:0]   m_a = '0, m_b = '0;
    int unsigned m_scnt = 0;
    bit          m_ready = 0;

    task automatic step(input bit v, input bit [2:0] f, input bit s, input bit [31:0] a,
                        input bit [31:0] b, input bit rd, input bit fl, input bit rn);
        bit commit, dz, es, estall;
        bit [2:0] ef;
        bit [31:0] ea, eb;
        @(negedge clk);
        req_valid = v; req_f = f; req_sign = s; req_a = a; req_b = b;
        rd_hilo = rd; flush = fl; rst_n = rn;
        #1;
        ef = MD_NOP; es = m_s; ea = m_a; eb = m_b; dz = 0;
        commit = m_pend && (cyc == m_commit) && !fl && rn;
        if (commit) begin
            if (m_f == MD_DIV && m_b == 0) dz = 1;
            else ef = m_f;
        end
        if (!m_pend && v && !fl && (f == MD_MTHI || f == MD_MTLO)) begin
            ef = f; es = s; ea = a;
        end
        estall  = m_pend && (v || rd);
        m_ready = !m_pend && !fl;
        check("md_f", md_f, ef);
        check("md_sign", md_sign, es);
        check("md_a", md_a, ea);
        check("md_b", md_b, eb);
        check("busy", busy, m_pend);
        check("stall", stall, estall);
        check("req_ready", req_ready, m_ready);
        check("div_zero", div_zero, dz);
`ifdef MD_SCHED_STALL_CNT_EN
        check("stall_cnt", stall_cnt, m_scnt);
`endif
        @(posedge clk);
        if (!rn) begin
            m_pend = 0; m_f = '0; m_s = 0; m_a = '0; m_b = '0; m_scnt = 0;
        end else begin
            if (estall) m_scnt++;
            if (m_pend) begin
                if (fl || cyc == m_commit) m_pend = 0;
            end else if (v && !fl && (f == MD_MULT || f == MD_DIV)) begin
                m_pend   = 1;
                m_commit = cyc + ((f == MD_MULT) ? MUL_LAT : DIV_LAT);
                m_f = f; m_s = s; m_a = a; m_b = b;
            end
        end
        cyc++;
    endtask

    task automatic idle(input int n, input bit rd);
        for (int i = 0; i < n; i++) step(0, MD_NOP, 0, 0, 0, rd, 0, 1);
    endtask

    task automatic check_hilo(input string tag, input logic [63:0] exp);
        #1;
        check(tag, {hi, lo}, exp);
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int waited;
        rst_n = 0; req_valid = 0; req_f = '0; req_sign = 0;
        req_a = '0; req_b = '0; rd_hilo = 0; flush = 0;
        repeat (2) @(posedge clk);

        idle(1, 0);

        // MULT signed -3 * 7
        step(1, MD_MULT, 1, 32'hFFFF_FFFD, 32'd7, 0, 0, 1);
        idle(MUL_LAT, 0);
        check_hilo("mult_hilo", 64'hFFFF_FFFF_FFFF_FFEB);

        // DIV unsigned 100 / 7 followed by MFLO held
        step(1, MD_DIV, 0, 32'd100, 32'd7, 0, 0, 1);
        idle(DIV_LAT, 1);
        check_hilo("div_hilo", {32'd2, 32'd14});
        idle(1, 1);

        // MTHI re-presented behind a DIV
        step(1, MD_DIV, 0, 32'd1000, 32'd10, 0, 0, 1);
        idle(1, 0);
        waited = 0;
        do begin
            step(1, MD_MTHI, 0, 32'h55, 32'd0, 0, 0, 1);
            waited++;
        end while (!m_ready && waited < 64);
        check("mthi_wait", waited, DIV_LAT);
        check_hilo("mthi_hilo", {32'h55, 32'd100});

        // flush on the MULT commit cycle
        step(1, MD_MULT, 0, 32'd5, 32'd6, 0, 0, 1);
        idle(MUL_LAT - 1, 0);
        step(0, MD_NOP, 0, 0, 0, 0, 1, 1);
        idle(2, 0);
        check_hilo("flush_hilo", {32'h55, 32'd100});

        // divide by zero
        step(1, MD_DIV, 1, 32'd9, 32'd0, 0, 0, 1);
        idle(DIV_LAT + 1, 0);
        check_hilo("dz_hilo", {32'h55, 32'd100});

        // reset with cnt==10
        step(1, MD_DIV, 0, 32'd77, 32'd3, 0, 0, 1);
        idle(DIV_LAT - 11, 1);
        step(0, MD_NOP, 0, 0, 0, 1, 0, 0);
        idle(DIV_LAT + 4, 0);
        check_hilo("rst_hilo", {32'h55, 32'd100});

        // random traffic
        for (int i = 0; i < 3000; i++) begin
            bit [31:0] rb;
            rb = ($urandom_range(0, 7) == 0) ? 32'd0 : $urandom;
            step($urandom_range(0, 1) == 1, 3'($urandom_range(0, 7)), $urandom_range(0, 1) == 1,
                 $urandom, rb, $urandom_range(0, 3) == 0, $urandom_range(0, 19) == 0,
                 $urandom_range(0, 99) != 0);
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
